// File: rtl/dvfs_ramp_sequencer.sv
// Walks one power domain's voltage/frequency codes toward a requested target, one code step at a time.
// Voltage rises before and falls after any frequency move; each step waits for settle time (and pgood on voltage).
module dvfs_ramp_sequencer #(
    parameter int VW       = 2,
    parameter int FW       = 3,
    parameter int RST_V    = 1,
    parameter int RST_F    = 2,
    parameter int V_SETTLE = 8,
    parameter int F_SETTLE = 4,
    parameter int V_TMO    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [VW-1:0] tgt_v,
    input  logic [FW-1:0] tgt_f,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    input  logic          vr_pgood,
    output logic [VW-1:0] cur_v,
    output logic [FW-1:0] cur_f,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int SMAX = (V_SETTLE > F_SETTLE) ? V_SETTLE : F_SETTLE;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int TW   = $clog2(V_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_V_UP, S_F_ADJ, S_V_DOWN, S_WAIT_V, S_WAIT_F, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [VW-1:0] t_v;
    logic [FW-1:0] t_f;
    logic [SW-1:0] settle;
    logic [TW-1:0] tmo;
    logic          v_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tgt_valid) state_nxt = S_SEL;
            S_SEL: begin
                if (t_v > cur_v)       state_nxt = S_V_UP;
                else if (t_f != cur_f) state_nxt = S_F_ADJ;
                else if (t_v < cur_v)  state_nxt = S_V_DOWN;
                else                   state_nxt = S_DONE;
            end
            S_V_UP, S_V_DOWN: state_nxt = S_WAIT_V;
            S_F_ADJ:  state_nxt = S_WAIT_F;
            S_WAIT_V: begin
                if (settle == '0 && vr_pgood) state_nxt = S_SEL;
                else if (v_timeout)           state_nxt = S_DONE;
            end
            S_WAIT_F: if (settle == '0) state_nxt = S_SEL;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // tmo always outlives settle, so tmo==0 only fires once settle has also expired
    always_comb begin
        tgt_ready = (state == S_IDLE);
        v_timeout = (state == S_WAIT_V) && (tmo == '0) && !vr_pgood;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_v  <= VW'(RST_V);
            cur_f  <= FW'(RST_F);
            t_v    <= VW'(RST_V);
            t_f    <= FW'(RST_F);
            settle <= '0;
            tmo    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: if (tgt_valid) begin
                    t_v <= tgt_v;
                    t_f <= tgt_f;
                    err <= 1'b0;
                end
                S_V_UP, S_V_DOWN: begin
                    cur_v  <= (state == S_V_UP) ? cur_v + 1'b1 : cur_v - 1'b1;
                    settle <= SW'(V_SETTLE - 1);
                    tmo    <= TW'(V_TMO - 1);
                end
                S_F_ADJ: begin
                    cur_f  <= (t_f > cur_f) ? cur_f + 1'b1 : cur_f - 1'b1;
                    settle <= SW'(F_SETTLE - 1);
                end
                S_WAIT_V: begin
                    if (settle != '0) settle <= settle - 1'b1;
                    if (tmo != '0)    tmo    <= tmo - 1'b1;
                    if (v_timeout)    err    <= 1'b1;
                end
                S_WAIT_F: if (settle != '0) settle <= settle - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dvfs_ramp_sequencer.sv
// Randomized scoreboard bench for dvfs_ramp_sequencer: a step-list model predicts every code change,
// the final codes, err and done latency; a negedge monitor compares as the DUT produces them.
module tb_dvfs_ramp_sequencer;
    localparam int VW = 2, FW = 3, RST_V = 1, RST_F = 2;
    localparam int V_SETTLE = 8, F_SETTLE = 4, V_TMO = 64;

    logic          clk = 0, rst_n = 0;
    logic [VW-1:0] tgt_v = '0;
    logic [FW-1:0] tgt_f = '0;
    logic          tgt_valid = 0, tgt_ready, vr_pgood = 1;
    logic [VW-1:0] cur_v;
    logic [FW-1:0] cur_f;
    logic          busy, done, err;

    dvfs_ramp_sequencer #(.VW(VW), .FW(FW), .RST_V(RST_V), .RST_F(RST_F),
        .V_SETTLE(V_SETTLE), .F_SETTLE(F_SETTLE), .V_TMO(V_TMO)) dut (
        .clk(clk), .rst_n(rst_n), .tgt_v(tgt_v), .tgt_f(tgt_f), .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready), .vr_pgood(vr_pgood), .cur_v(cur_v), .cur_f(cur_f),
        .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    typedef struct { int v; int f; bit e; int lat; int acc; } exp_t;
    exp_t exp_q[$];
    int   step_q[$];
    exp_t me;

    int checks = 0, fails = 0;
    int cyc = 0, acc_cyc = 0, last_done = 0;
    int mv = RST_V, mf = RST_F;
    int mpv = RST_V, mpf = RST_F;
    bit in_seq = 0, post_done = 0;
    bit pg_stuck = 0;
    int pg_d = 0, pg_cnt = 0, pg_prev = RST_V;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Regulator model: pgood drops for pg_d cycles after every voltage code change
    always begin
        @(posedge clk);
        #1;
        if (int'(cur_v) != pg_prev) begin
            pg_cnt  = pg_d;
            pg_prev = int'(cur_v);
        end else if (pg_cnt > 0) pg_cnt--;
        vr_pgood = !pg_stuck && (pg_cnt == 0);
    end

    // Reference: list each code change and total cycles; p = cycle in WAIT_V when pgood is first seen
    task automatic model_push(input int tv, input int tf, input int p, input bit stuck, input int acc);
        int t = 0, v = mv, f = mf;
        bit e = 0;
        while (v < tv && !e) begin
            v++;
            step_q.push_back(v * 16 + f);
            if (stuck) begin t += 2 + V_TMO; e = 1; end
            else t += 2 + ((p > V_SETTLE) ? p : V_SETTLE);
        end
        while (!e && f != tf) begin
            f += (tf > f) ? 1 : -1;
            step_q.push_back(v * 16 + f);
            t += 2 + F_SETTLE;
        end
        while (!e && v > tv) begin
            v--;
            step_q.push_back(v * 16 + f);
            if (stuck) begin t += 2 + V_TMO; e = 1; end
            else t += 2 + ((p > V_SETTLE) ? p : V_SETTLE);
        end
        t += e ? 1 : 2;
        exp_q.push_back('{v, f, e, t, acc});
        mv = v;
        mf = f;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mpv = int'(cur_v);
            mpf = int'(cur_f);
        end else begin
            if (int'(cur_v) != mpv || int'(cur_f) != mpf) begin
                if (step_q.size() == 0) chk("unexpected_step", step_q.size(), 1);
                else chk("step_code", int'(cur_v) * 16 + int'(cur_f), step_q.pop_front());
                mpv = int'(cur_v);
                mpf = int'(cur_f);
            end
            if (in_seq) chk("ready_while_busy", tgt_ready, 0);
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    me = exp_q.pop_front();
                    chk("final_v", cur_v, me.v);
                    chk("final_f", cur_f, me.f);
                    chk("err_at_done", err, me.e);
                    chk("done_latency", cyc - me.acc + 1, me.lat);
                    chk("busy_at_done", busy, 1);
                    chk("steps_left", step_q.size(), 0);
                end
                in_seq = 0;
                last_done = cyc;
                post_done = 1;
            end else if (post_done) begin
                chk("ready_after_done", tgt_ready, 1);
                chk("idle_after_done", busy, 0);
                post_done = 0;
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input int tv, input int tf, input int p, input bit stuck);
        int n = 0;
        tgt_v = VW'(tv);
        tgt_f = FW'(tf);
        tgt_valid = 1;
        while (!tgt_ready && n < 600) begin @(negedge clk); n++; end
        if (!tgt_ready) begin
            chk("accept_timeout", tgt_ready, 1);
            tgt_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        pg_stuck = stuck;
        pg_d     = p - 1;
        model_push(tv, tf, p, stuck, cyc);
        in_seq = 1;
        chk("err_clear_on_accept", err, 0);
        @(negedge clk);
        tgt_valid = 0;
        tgt_v = VW'($urandom);
        tgt_f = FW'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (in_seq && n < 600) begin @(negedge clk); n++; end
        if (in_seq) begin
            chk("done_timeout", in_seq, 0);
            in_seq = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cur_v", cur_v, RST_V);
        chk("rst_cur_f", cur_f, RST_F);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", tgt_ready, 1);
        rst_n = 1;
        @(negedge clk);

        issue(1, 2, 1, 0);                 // null request
        wait_done();
        issue(3, 7, 1, 0);                 // raise: 52-cycle sequence
        wait_done();
        issue(0, 0, 1, 0);                 // lower: all f steps before v steps
        issue(1, 2, 5, 0);                 // held during the sequence above
        chk("held_accept_cycle", acc_cyc, last_done + 2);
        wait_done();
        issue(2, 2, 1, 1);                 // pgood stuck low -> timeout
        wait_done();
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        for (int i = 0; i < 40; i++)
            begin
                issue($urandom % 4, $urandom % 8, 1 + $urandom % 16, ($urandom % 8) == 0);
                wait_done();
            end

        issue(1, 2, 1, 0);
        wait_done();
        issue(3, 2, 1, 1);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 0;
        exp_q.delete();
        step_q.delete();
        in_seq = 0;
        post_done = 0;
        pg_stuck = 0;
        mv = RST_V;
        mf = RST_F;
        #1;
        chk("async_rst_v", cur_v, RST_V);
        chk("async_rst_f", cur_f, RST_F);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", tgt_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
        end
        issue(2, 5, 3, 0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
